// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer.
// Contents:
//   state_e         - sequencer FSM states
//   entry_t         - one pattern ROM word {note, dur, oct_up, oct_dn, trem}
//   END_NOTE        - note code that marks the end of the pattern
//   PATTERN         - the fixed note pattern played by the sequencer
//   sanitize_entry  - clears contradictory octave flags
package music_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PLAY   = 3'd2,
        GAP    = 3'd3,
        PAUSED = 3'd4,
        END    = 3'd5
    } state_e;

    localparam int NOTE_W    = 4;
    localparam int DUR_W     = 4;
    localparam int ENTRY_W   = NOTE_W + DUR_W + 3;
    localparam int PAT_DEPTH = 16;
    localparam int PAT_AW    = 4;

    localparam logic [NOTE_W-1:0] END_NOTE = 4'hF;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;     // beats - 1
        logic              oct_up;
        logic              oct_dn;
        logic              trem;
    } entry_t;

    localparam logic [ENTRY_W-1:0] END_WORD = {END_NOTE, 4'h0, 3'b000};

    localparam logic [ENTRY_W-1:0] PATTERN [PAT_DEPTH] = '{
        {4'h1, 4'h0, 3'b000},
        {4'h5, 4'h2, 3'b100},
        {4'h0, 4'h0, 3'b000},
        {4'h3, 4'h1, 3'b011},
        END_WORD, END_WORD, END_WORD, END_WORD,
        END_WORD, END_WORD, END_WORD, END_WORD,
        END_WORD, END_WORD, END_WORD, END_WORD
    };

    // Octave up and down together is meaningless for the datapath; drop both.
    function automatic entry_t sanitize_entry(input entry_t e);
        entry_t r;
        r = e;
        if (e.oct_up && e.oct_dn) begin
            r.oct_up = 1'b0;
            r.oct_dn = 1'b0;
        end else begin
            r = e;
        end
        return r;
    endfunction

endpackage

// File: rtl/music_pattern_rom.sv
// Registered-output pattern ROM. Data for an address appears one clock later.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset (clears the output register)
//   i_addr  - pattern index
//   o_data  - registered pattern entry
module music_pattern_rom
    import music_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [$clog2(SEQ_LEN)-1:0] i_addr,
    output entry_t                     o_data
);

    entry_t w_data;
    entry_t r_data;

    // Address decode; indices beyond the stored pattern read as end markers.
    always_comb begin
        w_data = entry_t'(END_WORD);
        if (32'(i_addr) < 32'(PAT_DEPTH)) begin
            w_data = entry_t'(PATTERN[PAT_AW'(i_addr)]);
        end else begin
            w_data = entry_t'(END_WORD);
        end
    end

    // Output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/music_sequencer.sv
// Autonomous note sequencer feeding the musicfeatures tone/effects datapath.
// Walks the pattern ROM, generates the beat tick, holds each note for its
// duration and optionally inserts a silent tick between notes.
// Ports:
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_start           - level, rising edge starts playback from step 0
//   i_stop            - level, aborts to IDLE (highest priority)
//   i_pause           - level, freezes playback while high
//   i_loop_en         - restart at step 0 when the sequence ends
//   o_note_code       - current note (0 = rest)
//   o_octave_uena/o_octave_dena/o_tremolo_ena - effect enables
//   o_led_ena         - a non-rest note is sounding
//   o_step            - current ROM index
//   o_busy            - not IDLE
//   o_done            - one-cycle pulse when a non-looping sequence completes
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned TEMPO_DIV = 12500,
    parameter int unsigned SEQ_LEN   = 16,
    parameter bit          GAP_EN    = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_pause,
    input  logic                       i_loop_en,
    output logic [3:0]                 o_note_code,
    output logic                       o_octave_uena,
    output logic                       o_octave_dena,
    output logic                       o_tremolo_ena,
    output logic                       o_led_ena,
    output logic [$clog2(SEQ_LEN)-1:0] o_step,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned STEP_W = $clog2(SEQ_LEN);
    localparam int unsigned CNT_W  = $clog2(TEMPO_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TEMPO_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);

    state_e              r_state, w_state_nxt;
    logic                r_resume_gap, w_resume_gap_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DUR_W-1:0]    r_dur, w_dur_nxt;
    logic [STEP_W-1:0]   r_step, w_step_nxt;
    logic                r_start_d;
    logic [NOTE_W-1:0]   r_note, w_note_nxt;
    logic                r_oct_u, w_oct_u_nxt;
    logic                r_oct_d, w_oct_d_nxt;
    logic                r_trem, w_trem_nxt;
    logic                r_led, w_led_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    entry_t              w_rom_data;
    entry_t              w_entry;
    logic                w_tick;
    logic                w_start_edge;
    logic                w_advance;
    logic                w_clear_out;

    // The ROM is addressed with the next step so its registered output is
    // already valid during the LOAD cycle.
    music_pattern_rom #(
        .SEQ_LEN (SEQ_LEN)
    ) u_rom (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_addr (w_step_nxt),
        .o_data (w_rom_data)
    );

    assign w_entry      = sanitize_entry(w_rom_data);
    assign w_start_edge = i_start & ~r_start_d;
    assign w_tick       = ((r_state == PLAY) || (r_state == GAP)) && (r_cnt == CNT_LAST);

    // Next-state, counters and next output values.
    always_comb begin
        w_state_nxt      = r_state;
        w_resume_gap_nxt = r_resume_gap;
        w_cnt_nxt        = r_cnt;
        w_dur_nxt        = r_dur;
        w_step_nxt       = r_step;
        w_note_nxt       = r_note;
        w_oct_u_nxt      = r_oct_u;
        w_oct_d_nxt      = r_oct_d;
        w_trem_nxt       = r_trem;
        w_led_nxt        = r_led;
        w_done_nxt       = 1'b0;
        w_advance        = 1'b0;
        w_clear_out      = 1'b0;

        if (i_stop) begin
            w_state_nxt      = IDLE;
            w_step_nxt       = '0;
            w_cnt_nxt        = '0;
            w_resume_gap_nxt = 1'b0;
            w_clear_out      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt   = '0;
                    w_step_nxt  = '0;
                    w_clear_out = 1'b1;
                    if (w_start_edge) begin
                        w_state_nxt = LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                LOAD: begin
                    w_cnt_nxt = '0;
                    if (w_entry.note == END_NOTE) begin
                        w_state_nxt = END;
                        w_clear_out = 1'b1;
                    end else begin
                        w_state_nxt = PLAY;
                        w_dur_nxt   = w_entry.dur;
                        w_note_nxt  = w_entry.note;
                        w_oct_u_nxt = w_entry.oct_up;
                        w_oct_d_nxt = w_entry.oct_dn;
                        w_trem_nxt  = w_entry.trem;
                        w_led_nxt   = (w_entry.note != 4'h0);
                    end
                end
                PLAY: begin
                    if (i_pause) begin
                        // Counter holds on the pausing cycle: it is not an active clock.
                        w_state_nxt      = PAUSED;
                        w_resume_gap_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
                        if (w_tick && (r_dur != 4'd0)) begin
                            w_dur_nxt = r_dur - 4'd1;
                        end else if (w_tick && GAP_EN) begin
                            w_state_nxt = GAP;
                            w_clear_out = 1'b1;
                        end else if (w_tick) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_nxt = PLAY;
                        end
                    end
                end
                GAP: begin
                    if (i_pause) begin
                        w_state_nxt      = PAUSED;
                        w_resume_gap_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
                        w_advance = w_tick;
                    end
                end
                PAUSED: begin
                    if (!i_pause) begin
                        w_state_nxt = r_resume_gap ? GAP : PLAY;
                    end else begin
                        w_state_nxt = PAUSED;
                    end
                end
                END: begin
                    w_cnt_nxt   = '0;
                    w_step_nxt  = '0;
                    w_clear_out = 1'b1;
                    if (i_loop_en) begin
                        w_state_nxt = LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_step_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_clear_out = 1'b1;
                end
            endcase

            // Moving to the next entry; the last ROM slot wraps and ends the sequence.
            if (w_advance) begin
                w_clear_out = 1'b1;
                w_cnt_nxt   = '0;
                if (r_step == STEP_LAST) begin
                    w_step_nxt  = '0;
                    w_state_nxt = END;
                end else begin
                    w_step_nxt  = r_step + STEP_W'(1);
                    w_state_nxt = LOAD;
                end
            end else begin
                w_cnt_nxt = w_cnt_nxt;
            end
        end

        if (w_clear_out) begin
            w_note_nxt  = 4'h0;
            w_oct_u_nxt = 1'b0;
            w_oct_d_nxt = 1'b0;
            w_trem_nxt  = 1'b0;
            w_led_nxt   = 1'b0;
        end else begin
            w_note_nxt = w_note_nxt;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_resume_gap <= 1'b0;
            r_cnt        <= '0;
            r_dur        <= '0;
            r_step       <= '0;
            r_start_d    <= 1'b0;
            r_note       <= 4'h0;
            r_oct_u      <= 1'b0;
            r_oct_d      <= 1'b0;
            r_trem       <= 1'b0;
            r_led        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resume_gap <= w_resume_gap_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dur        <= w_dur_nxt;
            r_step       <= w_step_nxt;
            r_start_d    <= i_start;
            r_note       <= w_note_nxt;
            r_oct_u      <= w_oct_u_nxt;
            r_oct_d      <= w_oct_d_nxt;
            r_trem       <= w_trem_nxt;
            r_led        <= w_led_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign o_note_code   = r_note;
    assign o_octave_uena = r_oct_u;
    assign o_octave_dena = r_oct_d;
    assign o_tremolo_ena = r_trem;
    assign o_led_ena     = r_led;
    assign o_step        = r_step;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer (TEMPO_DIV=4, SEQ_LEN=16, GAP_EN=1).
module tb_music_sequencer;

    localparam int T  = 4;
    localparam int SL = 16;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_NOTE = 2;
    localparam int M_GAP  = 3;
    localparam int M_END  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] note_code;
    logic       octave_uena, octave_dena, tremolo_ena, led_ena;
    logic [3:0] step;
    logic       busy, done;

    always #5 clk = ~clk;

    music_sequencer #(
        .TEMPO_DIV (T),
        .SEQ_LEN   (SL),
        .GAP_EN    (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_pause       (pause),
        .i_loop_en     (loop_en),
        .o_note_code   (note_code),
        .o_octave_uena (octave_uena),
        .o_octave_dena (octave_dena),
        .o_tremolo_ena (tremolo_ena),
        .o_led_ena     (led_ena),
        .o_step        (step),
        .o_busy        (busy),
        .o_done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (phase + remaining active clocks) ----------------
    int         m_mode = M_IDLE;
    bit         m_paused = 1'b0;
    int         m_idx = 0;
    int         m_left = 0;
    bit         m_prev_start = 1'b0;
    bit         m_done = 1'b0;
    logic [3:0] m_note = 4'h0;
    logic       m_up = 1'b0, m_dn = 1'b0, m_tr = 1'b0;

    // The pattern as the music is written: note, beats-1, oct up, oct down, tremolo.
    task automatic pat_get(input int i, output int n, output int d, output bit u, output bit dn, output bit t);
        case (i)
            0:       begin n = 1;  d = 0; u = 0; dn = 0; t = 0; end
            1:       begin n = 5;  d = 2; u = 1; dn = 0; t = 0; end
            2:       begin n = 0;  d = 0; u = 0; dn = 0; t = 0; end
            3:       begin n = 3;  d = 1; u = 0; dn = 1; t = 1; end
            default: begin n = 15; d = 0; u = 0; dn = 0; t = 0; end
        endcase
    endtask

    task automatic model_next_entry();
        if (m_idx == SL - 1) begin
            m_idx  = 0;
            m_mode = M_END;
        end else begin
            m_idx  = m_idx + 1;
            m_mode = M_LOAD;
        end
    endtask

    task automatic model_step();
        bit edge_s;
        int n, d;
        bit u, dn, t;
        m_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_paused = 1'b0; m_idx = 0; m_left = 0; m_prev_start = 1'b0;
        end else begin
            edge_s = start && !m_prev_start;
            m_prev_start = start;
            if (stop) begin
                m_mode = M_IDLE; m_paused = 1'b0; m_idx = 0;
            end else if (m_paused) begin
                if (!pause) m_paused = 1'b0;
            end else begin
                case (m_mode)
                    M_IDLE: if (edge_s) begin m_mode = M_LOAD; m_idx = 0; end
                    M_LOAD: begin
                        pat_get(m_idx, n, d, u, dn, t);
                        if (n == 15) m_mode = M_END;
                        else begin
                            m_mode = M_NOTE;
                            m_left = (d + 1) * T;
                            m_note = 4'(n);
                            m_up   = u && !dn;
                            m_dn   = dn && !u;
                            m_tr   = t;
                        end
                    end
                    M_NOTE: begin
                        if (pause) m_paused = 1'b1;
                        else begin
                            m_left--;
                            if (m_left == 0) begin m_mode = M_GAP; m_left = T; end
                        end
                    end
                    M_GAP: begin
                        if (pause) m_paused = 1'b1;
                        else begin
                            m_left--;
                            if (m_left == 0) model_next_entry();
                        end
                    end
                    M_END: begin
                        m_idx = 0;
                        if (loop_en) m_mode = M_LOAD;
                        else begin m_mode = M_IDLE; m_done = 1'b1; end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    endtask

    function automatic logic [14:0] mk(input logic [3:0] n, input logic u, input logic dn, input logic t,
                                       input logic l, input logic [3:0] s, input logic b, input logic dd);
        return {n, u, dn, t, l, s, b, dd};
    endfunction

    function automatic logic [14:0] exp_vec();
        logic snd;
        snd = (m_mode == M_NOTE);
        return mk(snd ? m_note : 4'h0, snd & m_up, snd & m_dn, snd & m_tr,
                  snd && (m_note != 4'h0), 4'(m_idx), m_mode != M_IDLE, m_done);
    endfunction

    function automatic logic [14:0] act_vec();
        return {note_code, octave_uena, octave_dena, tremolo_ena, led_ena, step, busy, done};
    endfunction

    // One clock: advance the model with the inputs the DUT sees at this edge, then compare.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag, {17'd0, act_vec()}, {17'd0, exp_vec()});
    endtask

    // ---------------- table of directed vectors ----------------
    typedef struct {
        logic        start;
        logic        pause;
        logic        loop_en;
        int          n;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input int n, input logic [14:0] e);
        vec_t v;
        v.start = s; v.pause = 1'b0; v.loop_en = 1'b0; v.n = n; v.exp = e;
        tbl.push_back(v);
    endtask

    logic [14:0] snap;
    int          cnt5;
    int          done_cnt;
    logic [3:0]  step_snap;

    initial begin
        // Full non-looping pass through the pattern, cycle by cycle.
        add(1'b1, 1,  mk(4'h0, 0, 0, 0, 0, 4'd0, 1, 0));   // LOAD e0
        add(1'b0, 4,  mk(4'h1, 0, 0, 0, 1, 4'd0, 1, 0));   // e0, 1 beat
        add(1'b0, 4,  mk(4'h0, 0, 0, 0, 0, 4'd0, 1, 0));   // gap
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd1, 1, 0));   // LOAD e1
        add(1'b0, 12, mk(4'h5, 1, 0, 0, 1, 4'd1, 1, 0));   // e1, 3 beats, oct up
        add(1'b0, 4,  mk(4'h0, 0, 0, 0, 0, 4'd1, 1, 0));
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd2, 1, 0));
        add(1'b0, 4,  mk(4'h0, 0, 0, 0, 0, 4'd2, 1, 0));   // e2 rest, led off
        add(1'b0, 4,  mk(4'h0, 0, 0, 0, 0, 4'd2, 1, 0));
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd3, 1, 0));
        add(1'b0, 8,  mk(4'h3, 0, 1, 1, 1, 4'd3, 1, 0));   // e3, oct down + tremolo
        add(1'b0, 4,  mk(4'h0, 0, 0, 0, 0, 4'd3, 1, 0));
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd4, 1, 0));   // LOAD end marker
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd4, 1, 0));   // END
        add(1'b0, 1,  mk(4'h0, 0, 0, 0, 0, 4'd0, 0, 1));   // IDLE, done pulse
        add(1'b0, 3,  mk(4'h0, 0, 0, 0, 0, 4'd0, 0, 0));

        // Reset state.
        rst = 1'b1;
        cycle("reset");
        cycle("reset");
        check("reset_outputs", {17'd0, act_vec()}, 32'd0);
        rst = 1'b0;

        // Table run.
        for (int r = 0; r < tbl.size(); r++) begin
            start   = tbl[r].start;
            pause   = tbl[r].pause;
            loop_en = tbl[r].loop_en;
            for (int c = 0; c < tbl[r].n; c++) begin
                cycle("table_model");
                check($sformatf("table_row%0d_cyc%0d", r, c), {17'd0, act_vec()}, {17'd0, tbl[r].exp});
            end
        end
        start = 1'b0;

        // Looping: END returns to step 0 without a done pulse.
        loop_en = 1'b1;
        start = 1'b1;
        cycle("loop");
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 100 && m_mode != M_END; i++) begin
            cycle("loop");
            if (done) done_cnt++;
        end
        check("loop_reached_end", {28'd0, step}, 32'd4);
        cycle("loop");
        check("loop_step0", {28'd0, step}, 32'd0);
        check("loop_busy", {31'd0, busy}, 32'd1);
        if (done) done_cnt++;
        cycle("loop");
        check("loop_note1", {28'd0, note_code}, 32'd1);
        check("loop_no_done", done_cnt, 0);
        loop_en = 1'b0;
        stop = 1'b1;
        cycle("loop_stop");
        stop = 1'b0;
        cycle("idle");

        // Pause for 10 clocks in the middle of e1.
        start = 1'b1;
        cycle("pause");
        start = 1'b0;
        for (int i = 0; i < 40 && note_code != 4'h5; i++) cycle("pause");
        check("pause_found_e1", {28'd0, note_code}, 32'd5);
        cnt5 = 1;
        for (int i = 0; i < 4; i++) begin
            cycle("pause");
            if (note_code == 4'h5) cnt5++;
        end
        snap = act_vec();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle("pause");
            check("pause_frozen", {17'd0, act_vec()}, {17'd0, snap});
            if (note_code == 4'h5) cnt5++;
        end
        pause = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle("pause");
            if (note_code == 4'h5) cnt5++;
            else break;
        end
        check("pause_e1_samples", cnt5, 12 + 11);
        stop = 1'b1;
        cycle("pause_stop");
        stop = 1'b0;

        // Stop during a gap with start held high.
        start = 1'b1;
        cycle("stopgap");
        for (int i = 0; i < 20 && note_code != 4'h1; i++) cycle("stopgap");
        for (int i = 0; i < 20 && note_code != 4'h0; i++) cycle("stopgap");
        check("stopgap_in_gap", {31'd0, busy}, 32'd1);
        stop = 1'b1;
        cycle("stopgap");
        check("stopgap_idle", {17'd0, act_vec()}, 32'd0);
        stop = 1'b0;
        for (int i = 0; i < 5; i++) cycle("stopgap_held");
        check("stopgap_no_retrigger", {31'd0, busy}, 32'd0);
        start = 1'b0;
        cycle("stopgap");
        start = 1'b1;
        cycle("stopgap");
        check("stopgap_new_edge", {31'd0, busy}, 32'd1);

        // Reset mid-play, then a start edge while busy is ignored.
        for (int i = 0; i < 60 && note_code != 4'h5; i++) cycle("rstplay");
        check("rstplay_in_e1", {28'd0, note_code}, 32'd5);
        rst = 1'b1;
        start = 1'b0;
        cycle("rstplay");
        check("rstplay_zero", {17'd0, act_vec()}, 32'd0);
        rst = 1'b0;
        start = 1'b1;
        cycle("busystart");
        for (int i = 0; i < 10 && note_code != 4'h1; i++) cycle("busystart");
        step_snap = step;
        start = 1'b0;
        cycle("busystart");
        start = 1'b1;
        cycle("busystart");
        check("busystart_step", {28'd0, step}, {28'd0, step_snap});
        check("busystart_note", {28'd0, note_code}, 32'd1);
        start = 1'b0;
        stop = 1'b1;
        cycle("busystart");
        stop = 1'b0;

        // Randomised stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            stop = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0)  start = ~start;
            if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
